rojobot_wb_poller: RTL and testbench

- Hardware Wishbone initiator that drives the rojobot controller's register block without a CPU.
- Polls the update-sync register. On an update it:
  - reads BOT_INFO,
  - publishes BOT_INFO to fabric logic,
  - writes a motor command if that command changed,
  - pulses the interrupt-acknowledge register (write 1, then write 0).
- Lives in the 100 MHz domain on the same bus segment as the rojobot controller.
- Used for autonomous-demo mode and as the bus-functional stimulus source in system tests.

---
 rtl/rojobot_wb_poller_if.sv | 26 ++
 rtl/rojobot_wb_poller.sv | 183 ++++++++++++++++++
 tb/tb_rojobot_wb_poller.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rojobot_wb_poller_if.sv
// Wishbone classic bus between the rojobot poller (master) and the rojobot
// register block (slave).
interface rojobot_wb_poller_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rtry_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rtry_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rtry_i
  );
endinterface

// File: rtl/rojobot_wb_poller.sv
// CPU-less Wishbone initiator: polls UPDATE_SYNC, fetches BOT_INFO, pushes a
// changed motor command and pulses INT_ACK on every rojobot update.
module rojobot_wb_poller #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned POLL_INTERVAL = 16,
  parameter int unsigned ACK_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  mot_cmd,
  input  logic        clear_err,
  output logic [31:0] bot_info,
  output logic        info_valid,
  output logic        busy,
  output logic        bus_err,
  rojobot_wb_poller_if.master wb
);

  typedef enum logic [2:0] {
    IDLE, WAIT, RD_SYNC, RD_INFO, WR_CTRL, WR_ACK1, WR_ACK0, GAP
  } state_t;

  localparam logic [15:0] WAIT_LOAD = 16'(POLL_INTERVAL - 1);
  localparam logic [15:0] TMO_LIMIT = 16'(ACK_TIMEOUT);

  state_t      state, state_d;
  state_t      ret, ret_d;
  logic [15:0] cnt, cnt_d;
  logic        cyc, cyc_d;
  logic        we, we_d;
  logic [31:0] adr, adr_d;
  logic [31:0] dat, dat_d;
  logic [31:0] bot_info_d;
  logic        info_valid_d;
  logic        busy_d;
  logic        bus_err_d;
  logic [7:0]  last_sent, last_sent_d;
  logic        sent_valid, sent_valid_d;
  logic [7:0]  cmd_q, cmd_d;

  logic        launch;
  logic        err_set;
  logic        failed;
  logic        done;
  state_t      idle_or_wait;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ret        <= IDLE;
      cnt        <= '0;
      cyc        <= 1'b0;
      we         <= 1'b0;
      adr        <= '0;
      dat        <= '0;
      bot_info   <= '0;
      info_valid <= 1'b0;
      busy       <= 1'b0;
      bus_err    <= 1'b0;
      last_sent  <= '0;
      sent_valid <= 1'b0;
      cmd_q      <= '0;
    end else begin
      state      <= state_d;
      ret        <= ret_d;
      cnt        <= cnt_d;
      cyc        <= cyc_d;
      we         <= we_d;
      adr        <= adr_d;
      dat        <= dat_d;
      bot_info   <= bot_info_d;
      info_valid <= info_valid_d;
      busy       <= busy_d;
      bus_err    <= bus_err_d;
      last_sent  <= last_sent_d;
      sent_valid <= sent_valid_d;
      cmd_q      <= cmd_d;
    end
  end

  always_comb begin
    state_d      = state;
    ret_d        = ret;
    cnt_d        = cnt;
    cyc_d        = cyc;
    we_d         = we;
    adr_d        = adr;
    dat_d        = dat;
    bot_info_d   = bot_info;
    info_valid_d = 1'b0;
    last_sent_d  = last_sent;
    sent_valid_d = sent_valid;
    cmd_d        = cmd_q;
    launch       = 1'b0;
    err_set      = 1'b0;
    idle_or_wait = enable ? WAIT : IDLE;
    // an ack arriving in the timeout cycle still counts as success; err/rtry always win
    failed = wb.wb_err_i | wb.wb_rtry_i | (!wb.wb_ack_i && (cnt >= TMO_LIMIT));
    done   = failed | wb.wb_ack_i;

    case (state)
      IDLE: begin
        if (enable) begin
          state_d = WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_d = RD_SYNC;
          launch  = 1'b1;
        end else begin
          cnt_d = cnt - 16'd1;
        end
      end
      // GAP gives the mandatory idle bus cycle before the next transaction
      GAP: begin
        state_d = ret;
        if (ret == WAIT)      cnt_d  = WAIT_LOAD;
        else if (ret != IDLE) launch = 1'b1;
      end
      default: begin
        if (done) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = '0;
          state_d = GAP;
          if (failed) begin
            err_set = 1'b1;
            ret_d   = (state inside {RD_INFO, WR_CTRL, WR_ACK1}) ? WR_ACK0 : idle_or_wait;
          end else begin
            case (state)
              RD_SYNC: ret_d = wb.wb_dat_i[0] ? RD_INFO : idle_or_wait;
              RD_INFO: begin
                bot_info_d   = wb.wb_dat_i;
                info_valid_d = 1'b1;
                cmd_d        = mot_cmd;
                ret_d        = (mot_cmd != last_sent || !sent_valid) ? WR_CTRL : WR_ACK1;
              end
              WR_CTRL: begin
                last_sent_d  = cmd_q;
                sent_valid_d = 1'b1;
                ret_d        = WR_ACK1;
              end
              WR_ACK1: ret_d = WR_ACK0;
              WR_ACK0: ret_d = idle_or_wait;
              default: ret_d = idle_or_wait;
            endcase
          end
        end else if (cnt != '1) begin
          cnt_d = cnt + 16'd1;
        end
      end
    endcase

    if (launch) begin
      cyc_d = 1'b1;
      cnt_d = 16'd1;
      case (state_d)
        RD_SYNC: begin adr_d = BASE_ADDR + 32'h14; we_d = 1'b0; dat_d = '0;              end
        RD_INFO: begin adr_d = BASE_ADDR + 32'h0C; we_d = 1'b0; dat_d = '0;              end
        WR_CTRL: begin adr_d = BASE_ADDR + 32'h10; we_d = 1'b1; dat_d = {24'h0, cmd_d}; end
        WR_ACK1: begin adr_d = BASE_ADDR + 32'h18; we_d = 1'b1; dat_d = 32'h1;          end
        WR_ACK0: begin adr_d = BASE_ADDR + 32'h18; we_d = 1'b1; dat_d = 32'h0;          end
        default: begin cyc_d = 1'b0;                                                    end
      endcase
    end

    busy_d    = !(state_d inside {IDLE, WAIT});
    bus_err_d = err_set ? 1'b1 : (clear_err ? 1'b0 : bus_err);
  end

  assign wb.wb_adr_o = adr;
  assign wb.wb_dat_o = dat;
  assign wb.wb_sel_o = 4'b0001;
  assign wb.wb_we_o  = we;
  assign wb.wb_cyc_o = cyc;
  assign wb.wb_stb_o = cyc;
  assign wb.wb_cti_o = 3'b000;
  assign wb.wb_bte_o = 2'b00;

endmodule

// File: tb/tb_rojobot_wb_poller.sv
// Directed bench for rojobot_wb_poller against a 1-cycle-ack register-block model.
module tb_rojobot_wb_poller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  mot_cmd = 8'h00;
  logic        clear_err = 1'b0;
  logic [31:0] bot_info;
  logic        info_valid;
  logic        busy;
  logic        bus_err;

  rojobot_wb_poller_if bus ();

  rojobot_wb_poller #(
    .BASE_ADDR    (32'h0000_0000),
    .POLL_INTERVAL(4),
    .ACK_TIMEOUT  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mot_cmd   (mot_cmd),
    .clear_err (clear_err),
    .bot_info  (bot_info),
    .info_valid(info_valid),
    .busy      (busy),
    .bus_err   (bus_err),
    .wb        (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // register-block model: one-shot update flag, BOT_INFO value, fault injection
  int unsigned sync_req = 0;
  int unsigned sync_served = 0;
  logic [31:0] info_reg = 32'h1234_0A05;
  logic        hang_info = 1'b0;
  logic        err_ctrl = 1'b0;

  assign bus.wb_rtry_i = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.wb_ack_i <= 1'b0;
      bus.wb_err_i <= 1'b0;
      bus.wb_dat_i <= '0;
    end else begin
      bus.wb_ack_i <= 1'b0;
      bus.wb_err_i <= 1'b0;
      if (bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_ack_i && !bus.wb_err_i &&
          !(hang_info && bus.wb_adr_o == 32'h0C)) begin
        bus.wb_ack_i <= 1'b1;
        bus.wb_err_i <= err_ctrl && (bus.wb_adr_o == 32'h10);
        case (bus.wb_adr_o)
          32'h14: begin
            bus.wb_dat_i <= {31'b0, sync_req != sync_served};
            if (sync_req != sync_served) sync_served <= sync_served + 1;
          end
          32'h0C:  bus.wb_dat_i <= info_reg;
          default: bus.wb_dat_i <= '0;
        endcase
      end
    end
  end

  // bus monitor: one record per completed (cyc-high) transaction
  typedef struct {
    int unsigned cyc0;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    int unsigned len;
  } txn_t;

  txn_t        txq[$];
  txn_t        cur;
  int unsigned cur_len = 0;
  int unsigned cyc_cnt = 0;
  int unsigned n_ack0 = 0;
  int unsigned n_info = 0;
  int unsigned n_fall = 0;
  int unsigned fall_cycle = 0;
  logic [31:0] info_seen = '0;
  logic        prev_cyc = 1'b0;
  logic        prev_busy = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (bus.wb_cyc_o && !prev_cyc) begin
      cur.cyc0 = cyc_cnt;
      cur.adr  = bus.wb_adr_o;
      cur.dat  = bus.wb_dat_o;
      cur.we   = bus.wb_we_o;
      cur_len  = 1;
    end else if (bus.wb_cyc_o) begin
      cur_len++;
    end
    if (!bus.wb_cyc_o && prev_cyc) begin
      cur.len = cur_len;
      txq.push_back(cur);
      if (cur.adr == 32'h18 && cur.we && cur.dat == 32'h0) n_ack0++;
    end
    if (info_valid) begin
      n_info++;
      info_seen = bot_info;
    end
    if (prev_busy && !busy) begin
      n_fall++;
      fall_cycle = cyc_cnt;
    end
    prev_cyc  = bus.wb_cyc_o;
    prev_busy = busy;
  end

  task automatic wait_update();
    int unsigned base = n_ack0;
    int unsigned fb;
    logic ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (n_ack0 > base) begin ok = 1'b1; break; end
    end
    chk("upd_int_ack0_seen", 32'(ok), 32'd1);
    fb = n_fall;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (n_fall > fb) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("upd_busy_fall", 32'(ok), 32'd1);
  endtask

  task automatic find_seq(output int s);
    s = -1;
    for (int i = int'(txq.size()) - 1; i >= 1; i--) begin
      if (txq[i].adr == 32'h0C) begin s = i - 1; break; end
    end
    chk("seq_found", 32'(s >= 0), 32'd1);
    if (s < 0) s = 0;
  endtask

  task automatic exp_txn(input string tag, input int idx, input logic [31:0] adr,
                         input logic we, input logic [31:0] dat);
    logic present;
    present = (idx >= 0) && (idx < int'(txq.size()));
    chk({tag, "_present"}, 32'(present), 32'd1);
    if (present) begin
      chk({tag, "_adr"}, txq[idx].adr, adr);
      chk({tag, "_we"}, 32'(txq[idx].we), 32'(we));
      if (we) chk({tag, "_dat"}, txq[idx].dat, dat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int unsigned info0;
    int unsigned nq;
    logic ok;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(bus.wb_stb_o), 32'd0);
    chk("rst_we", 32'(bus.wb_we_o), 32'd0);
    chk("rst_adr", bus.wb_adr_o, 32'h0);
    chk("rst_dat", bus.wb_dat_o, 32'h0);
    chk("rst_sel", 32'(bus.wb_sel_o), 32'h1);
    chk("rst_cti_bte", 32'({bus.wb_cti_o, bus.wb_bte_o}), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_info", bot_info, 32'h0);
    chk("rst_valid", 32'(info_valid), 32'd0);

    // idle polling with UPDATE_SYNC=0: RD_SYNC every POLL_INTERVAL+3 = 7 cycles
    enable = 1'b1;
    mot_cmd = 8'h33;
    @(negedge clk);
    reset = 1'b0;
    repeat (45) @(negedge clk);
    chk("poll_count_ge5", 32'(txq.size() >= 5), 32'd1);
    for (int i = 0; i < int'(txq.size()); i++) begin
      chk("poll_adr", txq[i].adr, 32'h14);
      chk("poll_we", 32'(txq[i].we), 32'd0);
      chk("poll_len", 32'(txq[i].len), 32'd2);
      if (i > 0) chk("poll_period", 32'(txq[i].cyc0 - txq[i-1].cyc0), 32'd7);
    end
    chk("poll_no_info", 32'(n_info), 32'd0);

    // first update: control write included, 15 cycles
    info0 = n_info;
    sync_req++;
    wait_update();
    find_seq(s);
    chk("u1_len", 32'(int'(txq.size()) - s), 32'd5);
    exp_txn("u1_sync", s,     32'h14, 1'b0, 32'h0);
    exp_txn("u1_info", s + 1, 32'h0C, 1'b0, 32'h0);
    exp_txn("u1_ctrl", s + 2, 32'h10, 1'b1, 32'h33);
    exp_txn("u1_ack1", s + 3, 32'h18, 1'b1, 32'h1);
    exp_txn("u1_ack0", s + 4, 32'h18, 1'b1, 32'h0);
    chk("u1_latency", 32'(fall_cycle - txq[s].cyc0), 32'd15);
    chk("u1_pulses", 32'(n_info - info0), 32'd1);
    chk("u1_info_at_pulse", info_seen, 32'h1234_0A05);
    chk("u1_bot_info", bot_info, 32'h1234_0A05);

    // same command: no BOT_CTRL write, 12 cycles
    sync_req++;
    wait_update();
    find_seq(s);
    chk("u2_len", 32'(int'(txq.size()) - s), 32'd4);
    exp_txn("u2_info", s + 1, 32'h0C, 1'b0, 32'h0);
    exp_txn("u2_ack1", s + 2, 32'h18, 1'b1, 32'h1);
    exp_txn("u2_ack0", s + 3, 32'h18, 1'b1, 32'h0);
    chk("u2_latency", 32'(fall_cycle - txq[s].cyc0), 32'd12);

    // changed command is written
    mot_cmd = 8'h44;
    sync_req++;
    wait_update();
    find_seq(s);
    chk("u3_len", 32'(int'(txq.size()) - s), 32'd5);
    exp_txn("u3_ctrl", s + 2, 32'h10, 1'b1, 32'h44);
    chk("u3_latency", 32'(fall_cycle - txq[s].cyc0), 32'd15);
    chk("u3_no_err", 32'(bus_err), 32'd0);

    // BOT_INFO never acked: timeout after 8 cycles, straight to INT_ACK=0
    hang_info = 1'b1;
    info_reg = 32'h5555_AAAA;
    info0 = n_info;
    sync_req++;
    wait_update();
    find_seq(s);
    chk("to_len", 32'(int'(txq.size()) - s), 32'd3);
    exp_txn("to_info", s + 1, 32'h0C, 1'b0, 32'h0);
    if (s + 1 < int'(txq.size())) chk("to_cyc_len", 32'(txq[s + 1].len), 32'd8);
    exp_txn("to_ack0", s + 2, 32'h18, 1'b1, 32'h0);
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_bot_info", bot_info, 32'h1234_0A05);
    chk("to_no_pulse", 32'(n_info - info0), 32'd0);
    hang_info = 1'b0;
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("to_cleared", 32'(bus_err), 32'd0);

    // err together with ack on BOT_CTRL: last_sent must stay 8'h44
    mot_cmd = 8'h55;
    err_ctrl = 1'b1;
    sync_req++;
    wait_update();
    find_seq(s);
    chk("ec_len", 32'(int'(txq.size()) - s), 32'd4);
    exp_txn("ec_ctrl", s + 2, 32'h10, 1'b1, 32'h55);
    exp_txn("ec_ack0", s + 3, 32'h18, 1'b1, 32'h0);
    chk("ec_bus_err", 32'(bus_err), 32'd1);
    chk("ec_bot_info", bot_info, 32'h5555_AAAA);
    err_ctrl = 1'b0;
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    sync_req++;
    wait_update();
    find_seq(s);
    chk("ec_retry_len", 32'(int'(txq.size()) - s), 32'd5);
    exp_txn("ec_retry_ctrl", s + 2, 32'h10, 1'b1, 32'h55);
    chk("ec_retry_err", 32'(bus_err), 32'd0);

    // enable dropped during RD_INFO: finish through INT_ACK=0, then IDLE
    sync_req++;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.wb_cyc_o && bus.wb_adr_o == 32'h0C) begin ok = 1'b1; break; end
    end
    chk("en_saw_rd_info", 32'(ok), 32'd1);
    enable = 1'b0;
    wait_update();
    find_seq(s);
    chk("en_len", 32'(int'(txq.size()) - s), 32'd4);
    exp_txn("en_ack1", s + 2, 32'h18, 1'b1, 32'h1);
    exp_txn("en_ack0", s + 3, 32'h18, 1'b1, 32'h0);
    nq = txq.size();
    repeat (30) @(negedge clk);
    chk("en_idle_busy", 32'(busy), 32'd0);
    chk("en_idle_no_txn", 32'(txq.size()), 32'(nq));
    chk("en_idle_cyc", 32'(bus.wb_cyc_o), 32'd0);

    // reset while a transaction is in flight
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.wb_cyc_o) begin ok = 1'b1; break; end
    end
    chk("rs_saw_cyc", 32'(ok), 32'd1);
    reset = 1'b1;
    #1;
    chk("rs_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("rs_stb", 32'(bus.wb_stb_o), 32'd0);
    chk("rs_adr", bus.wb_adr_o, 32'h0);
    chk("rs_we", 32'(bus.wb_we_o), 32'd0);
    chk("rs_sel", 32'(bus.wb_sel_o), 32'h1);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_info", bot_info, 32'h0);
    chk("rs_valid", 32'(info_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
